// File: rtl/fp_pkg.sv
// fp_pkg -- shared definitions for the single-precision floating-point units.
// Holds the default operand geometry, the exponent bias, the canonical quiet
// NaN, the quotient iteration count, flag bit positions, the divider FSM
// state encoding and the per-operand classification record.
package fp_pkg;

  localparam int INT_W_DEF  = 9;
  localparam int FRAC_W_DEF = 23;
  localparam int DATA_W_DEF = INT_W_DEF + FRAC_W_DEF;

  localparam int EXP_BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // 24 mantissa bits + guard + one spare bit so that a quotient in [0.5,1)
  // still yields a full mantissa and guard after normalisation.
  localparam int DIV_ITERS = 26;

  // Bit positions inside the 4-bit flag vector.
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIV_ZERO  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Denormals are reported as zero because the arithmetic units flush them.
  typedef struct packed {
    logic sign;
    logic zero;
    logic inf;
    logic nan;
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// fp_classify -- combinational operand classifier shared by fp_div and fp_mul.
// Ports:
//   data : IEEE-754 operand
//   cls  : sign, zero (true zero or denormal), infinity, NaN
module fp_classify
  import fp_pkg::*;
#(
  parameter int INT_W  = INT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] data,
  output fp_class_t         cls
);

  localparam int EXP_W = INT_W - 1;

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign exp_f  = data[DATA_W-2 -: EXP_W];
  assign frac_f = data[FRAC_W-1:0];

  assign cls.sign = data[DATA_W-1];
  assign cls.zero = (exp_f == '0);
  assign cls.inf  = (&exp_f) && (frac_f == '0);
  assign cls.nan  = (&exp_f) && (frac_f != '0);

endmodule

// File: rtl/fp_div.sv
// fp_div -- multi-cycle IEEE-754 single-precision divider.
// Restoring division produces one quotient bit per cycle, followed by a
// single rounding cycle (round to nearest, ties to even). Denormal inputs and
// results are flushed to signed zero. Every operation, special cases
// included, takes the same number of cycles.
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   i_valid / o_ready   : operand handshake (o_ready only while idle)
//   i_data_a, i_data_b  : dividend, divisor
//   o_valid / i_ready   : result handshake, result held until i_ready
//   fp_div_o            : quotient a/b
//   o_flags             : {invalid, div_by_zero, overflow, underflow}
module fp_div
  import fp_pkg::*;
#(
  parameter int INT_W  = INT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic [DATA_W-1:0] i_data_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] fp_div_o,
  output logic [3:0]        o_flags
);

  localparam int EXP_W  = INT_W - 1;
  localparam int MANT_W = FRAC_W + 1;
  localparam int ES_W   = EXP_W + 3;
  localparam int CNT_W  = $clog2(DIV_ITERS);
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DIV_ITERS - 1);
  localparam logic signed [ES_W-1:0] EXP_MAX  = ES_W'((1 << EXP_W) - 1);
  localparam logic signed [ES_W-1:0] EXP_ZERO = '0;

  state_t state, state_next;

  logic [DATA_W-1:0]    a_reg, b_reg;
  logic [MANT_W:0]      rem, divisor, rem_diff, rem_next;
  logic                 rem_ge;
  logic [DIV_ITERS-1:0] quot;
  logic [CNT_W-1:0]     cnt;
  fp_class_t            cls_a, cls_b;

  logic                   lead, guard, sticky, round_up, carry, sign;
  logic [MANT_W-1:0]      mant;
  logic [MANT_W:0]        mant_r;
  logic [FRAC_W-1:0]      frac_r;
  logic signed [ES_W-1:0] exp_calc;
  logic [DATA_W-1:0]      result, inf_res, zero_res;
  logic [3:0]             flags;
  logic                   unused_bits;

  fp_classify #(.INT_W(INT_W), .FRAC_W(FRAC_W), .DATA_W(DATA_W)) u_cls_a (
    .data (a_reg),
    .cls  (cls_a)
  );

  fp_classify #(.INT_W(INT_W), .FRAC_W(FRAC_W), .DATA_W(DATA_W)) u_cls_b (
    .data (b_reg),
    .cls  (cls_b)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = DIV;
      end
      DIV:   if (cnt == CNT_LAST) state_next = ROUND;
      ROUND: state_next = DONE;
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One restoring step: the partial remainder stays below twice the divisor,
  // so after a conditional subtract the left shift never loses a set bit.
  assign divisor  = {1'b0, 1'b1, b_reg[FRAC_W-1:0]};
  assign rem_ge   = (rem >= divisor);
  assign rem_diff = rem - divisor;
  assign rem_next = rem_ge ? {rem_diff[MANT_W-1:0], 1'b0} : {rem[MANT_W-1:0], 1'b0};

  // Normalise the quotient: a clear leading bit means it lies in [0.5,1),
  // so take one more bit and lower the exponent by one.
  assign lead     = quot[DIV_ITERS-1];
  assign mant     = lead ? quot[DIV_ITERS-1:2] : quot[DIV_ITERS-2:1];
  assign guard    = lead ? quot[1] : quot[0];
  assign sticky   = (|rem) | (lead & quot[0]);
  assign round_up = guard & (sticky | mant[0]);
  assign mant_r   = {1'b0, mant} + {{MANT_W{1'b0}}, round_up};
  assign carry    = mant_r[MANT_W];
  assign frac_r   = carry ? '0 : mant_r[FRAC_W-1:0];
  assign exp_calc = ES_W'(a_reg[DATA_W-2 -: EXP_W]) - ES_W'(b_reg[DATA_W-2 -: EXP_W])
                  + ES_W'(EXP_BIAS) - ES_W'(!lead) + ES_W'(carry);

  assign sign     = cls_a.sign ^ cls_b.sign;
  assign inf_res  = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
  assign zero_res = {sign, {(DATA_W-1){1'b0}}};

  assign unused_bits = ^{rem_diff[MANT_W], mant_r[MANT_W-1]};

  // Result selection; special operands take priority over the arithmetic.
  always_comb begin
    result = '0;
    flags  = '0;
    if (cls_a.nan || cls_b.nan || (cls_a.zero && cls_b.zero) || (cls_a.inf && cls_b.inf)) begin
      result              = DATA_W'(QNAN);
      flags[FLAG_INVALID] = 1'b1;
    end else if (cls_a.inf) begin
      result = inf_res;
    end else if (cls_b.zero) begin
      result               = inf_res;
      flags[FLAG_DIV_ZERO] = 1'b1;
    end else if (cls_b.inf || cls_a.zero) begin
      result = zero_res;
    end else if (exp_calc >= EXP_MAX) begin
      result               = inf_res;
      flags[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_calc <= EXP_ZERO) begin
      result                = zero_res;
      flags[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      result = {sign, exp_calc[EXP_W-1:0], frac_r};
    end
  end

  // Operand capture, iteration and result registers. The remainder is
  // seeded straight from the incoming dividend so the first DIV cycle
  // already produces a quotient bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      rem      <= '0;
      quot     <= '0;
      cnt      <= '0;
      fp_div_o <= '0;
      o_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_reg <= i_data_a;
            b_reg <= i_data_b;
            rem   <= {1'b0, 1'b1, i_data_a[FRAC_W-1:0]};
            quot  <= '0;
            cnt   <= '0;
          end
        end
        DIV: begin
          quot <= {quot[DIV_ITERS-2:0], rem_ge};
          rem  <= rem_next;
          cnt  <= cnt + 1'b1;
        end
        ROUND: begin
          fp_div_o <= result;
          o_flags  <= flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div -- self-checking bench for fp_div.
// Directed cases use known IEEE-754 quotients; random cases are compared with
// a reference built on real-number division followed by rounding to single
// precision and the flush/overflow/special-value rules.
// Cycle numbering: the cycle in which the operands are accepted is cycle 0,
// and the quotient must first be valid in cycle 28.
module tb_fp_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data_a;
  logic [31:0] i_data_b;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] fp_div_o;
  logic [3:0]  o_flags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_div dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data_a (i_data_a),
    .i_data_b (i_data_b),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .fp_div_o (fp_div_o),
    .o_flags  (o_flags)
  );

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Widen a single to a double by re-biasing its exponent; denormals never
  // reach this point because the reference flushes them first.
  function automatic real to_real(input logic [31:0] x);
    logic [63:0] bits;
    bits = {1'b0, 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
    return $bitstoreal(bits);
  endfunction

  // Reference quotient and flags.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [3:0] f);
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
    real         qr;
    logic [63:0] qb;
    logic [24:0] m;
    int          e;
    a_zero = (a[30:23] == 8'd0);
    b_zero = (b[30:23] == 8'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    sgn    = a[31] ^ b[31];
    f      = 4'b0000;
    q      = {sgn, 31'd0};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      q = 32'h7FC00000;
      f = 4'b1000;
    end else if (a_inf) begin
      q = {sgn, 8'hFF, 23'd0};
    end else if (b_zero) begin
      q = {sgn, 8'hFF, 23'd0};
      f = 4'b0100;
    end else if (a_zero || b_inf) begin
      q = {sgn, 31'd0};
    end else begin
      qr = to_real(a) / to_real(b);
      qb = $realtobits(qr);
      e  = int'(qb[62:52]) - 1023 + 127;
      m  = {1'b0, 1'b1, qb[51:29]};
      if (qb[28] && ((|qb[27:0]) || m[0])) m = m + 25'd1;
      if (m[24]) begin
        e = e + 1;
        m = m >> 1;
      end
      if (e >= 255) begin
        q = {sgn, 8'hFF, 23'd0};
        f = 4'b0010;
      end else if (e <= 0) begin
        q = {sgn, 31'd0};
        f = 4'b0001;
      end else begin
        q = {sgn, e[7:0], m[22:0]};
      end
    end
  endfunction

  // Biased toward mid-range exponents, with a share of zeros, denormals,
  // infinities, NaNs and extreme exponents to reach every result class.
  function automatic logic [31:0] gen_operand();
    logic [7:0]  e;
    logic [22:0] fr;
    int          r;
    r  = int'($urandom_range(0, 15));
    fr = 23'($urandom);
    case (r)
      0:       e = 8'd0;
      1: begin
        e = 8'hFF;
        if ($urandom_range(0, 1) == 0) fr = 23'd0;
      end
      2:       e = 8'($urandom_range(1, 30));
      3:       e = 8'($urandom_range(225, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, fr};
  endfunction

  // Presents one operand pair in IDLE and waits (bounded) for the result.
  // While the divider is busy, i_valid toggles with junk data that must be
  // ignored. Returns the cycle number in which o_valid was first seen.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int cyc);
    checkOutput("ready_before_op", 32'(o_ready), 32'd1);
    i_data_a = a;
    i_data_b = b;
    i_valid  = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (o_valid !== 1'b1 && cyc < 64) begin
      i_valid  = 1'($urandom_range(0, 1));
      i_data_a = $urandom;
      i_data_b = $urandom;
      @(posedge clk); #1;
      cyc++;
    end
    i_valid = 1'b0;
  endtask

  // Consumes the result and confirms the block is idle again.
  task automatic releaseResult();
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    checkOutput("idle_after_take", 32'(o_ready), 32'd1);
    checkOutput("valid_after_take", 32'(o_valid), 32'd0);
  endtask

  logic [31:0] dir_a [13] = '{32'h40C00000, 32'h3F800000, 32'h00000000, 32'hBF800000,
                              32'h7F7FFFFF, 32'h00800000, 32'h7F800001, 32'h7F800000,
                              32'hFF800000, 32'h3F800000, 32'h00400000, 32'h3F800000,
                              32'hC0C00000};
  logic [31:0] dir_b [13] = '{32'h40400000, 32'h40400000, 32'h00000000, 32'h00000000,
                              32'h3F000000, 32'h40000000, 32'h3F800000, 32'hFF800000,
                              32'h40000000, 32'hFF800000, 32'h3F800000, 32'h80000001,
                              32'h40400000};
  logic [31:0] dir_q [13] = '{32'h40000000, 32'h3EAAAAAB, 32'h7FC00000, 32'hFF800000,
                              32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000,
                              32'hFF800000, 32'h80000000, 32'h00000000, 32'hFF800000,
                              32'hC0000000};
  logic [3:0]  dir_f [13] = '{4'h0, 4'h0, 4'h8, 4'h4, 4'h2, 4'h1, 4'h8, 4'h8,
                              4'h0, 4'h0, 4'h0, 4'h4, 4'h0};

  initial begin
    int          cyc;
    logic [31:0] exp_q;
    logic [3:0]  exp_f;

    rst      = 1'b1;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_data_a = '0;
    i_data_b = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(o_ready), 32'd1);
    checkOutput("reset_valid", 32'(o_valid), 32'd0);
    checkOutput("reset_result", fp_div_o, 32'd0);
    checkOutput("reset_flags", 32'(o_flags), 32'd0);

    // Directed cases; the first is offered in the very cycle reset drops.
    rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(dir_a[i], dir_b[i], cyc);
      checkOutput($sformatf("dir%0d_latency", i), 32'(cyc), 32'd28);
      checkOutput($sformatf("dir%0d_result", i), fp_div_o, dir_q[i]);
      checkOutput($sformatf("dir%0d_flags", i), 32'(o_flags), 32'(dir_f[i]));
      releaseResult();
    end

    // Back-pressure: result and handshakes hold while i_ready stays low.
    applyStimulus(32'h3F800000, 32'h40400000, cyc);
    checkOutput("hold_latency", 32'(cyc), 32'd28);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold%0d_result", i), fp_div_o, 32'h3EAAAAAB);
      checkOutput($sformatf("hold%0d_ready", i), 32'(o_ready), 32'd0);
      checkOutput($sformatf("hold%0d_valid", i), 32'(o_valid), 32'd1);
    end
    releaseResult();

    // Reset in the middle of a division discards it.
    i_data_a = 32'h40C00000;
    i_data_b = 32'h40400000;
    i_valid  = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midrst_valid", 32'(o_valid), 32'd0);
    checkOutput("midrst_ready", 32'(o_ready), 32'd1);
    checkOutput("midrst_result", fp_div_o, 32'd0);
    checkOutput("midrst_flags", 32'(o_flags), 32'd0);
    rst = 1'b0;
    applyStimulus(32'hBF800000, 32'h40400000, cyc);
    checkOutput("after_rst_latency", 32'(cyc), 32'd28);
    checkOutput("after_rst_result", fp_div_o, 32'hBEAAAAAB);
    releaseResult();

    // Random operands against the reference.
    for (int n = 0; n < 250; n++) begin
      logic [31:0] ra, rb;
      ra = gen_operand();
      rb = gen_operand();
      ref_div(ra, rb, exp_q, exp_f);
      applyStimulus(ra, rb, cyc);
      checkOutput($sformatf("rnd%0d_latency", n), 32'(cyc), 32'd28);
      checkOutput($sformatf("rnd%0d_result a=%h b=%h", n, ra, rb), fp_div_o, exp_q);
      checkOutput($sformatf("rnd%0d_flags a=%h b=%h", n, ra, rb), 32'(o_flags), 32'(exp_f));
      releaseResult();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_div.md
FP_DIV -- requirements
Module: fp_div

Interface
REQ-001 SHALL have parameter INT_W, default 9, meaning sign plus exponent bits.
REQ-002 SHALL have parameter FRAC_W, default 23, meaning fraction bits.
REQ-003 SHALL have parameter DATA_W, default 32, meaning operand/result width (INT_W+FRAC_W).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port i_valid, input, 1, operands present.
REQ-007 SHALL have port o_ready, output, 1, block can accept operands.
REQ-008 SHALL have port i_data_a, input, DATA_W, dividend (IEEE-754 single).
REQ-009 SHALL have port i_data_b, input, DATA_W, divisor (IEEE-754 single).
REQ-010 SHALL have port o_valid, output, 1, quotient present.
REQ-011 SHALL have port i_ready, input, 1, consumer accepts quotient.
REQ-012 SHALL have port fp_div_o, output, DATA_W, quotient a/b.
REQ-013 SHALL have port o_flags, output, 4, {invalid, div_by_zero, overflow, underflow}, valid with o_valid.

Function
REQ-014 SHALL use FSM states IDLE, DIV, ROUND, DONE; o_ready high only in IDLE.
REQ-015 SHALL accept operands on the cycle when i_valid and o_ready are both high, registering both inputs and moving IDLE->DIV.
REQ-016 SHALL produce quotient mantissa by restoring division, one bit per cycle, 26 DIV cycles, then DIV->ROUND.
REQ-017 SHALL assert o_valid exactly 28 cycles after acceptance for every operand class, special cases included (ROUND->DONE).
REQ-018 SHALL hold fp_div_o, o_flags, o_valid stable in DONE until i_ready is high, then return to IDLE the next cycle; i_valid SHALL be ignored outside IDLE.
REQ-019 SHALL compute sign = sign_a XOR sign_b, exponent = ea - eb + 127, decremented by one when the quotient leading bit is 0 (quotient range [0.5,2)).
REQ-020 SHALL round to nearest, ties to even, using guard bit plus sticky (remainder nonzero); mantissa carry-out SHALL increment the exponent.
REQ-021 SHALL flush denormal inputs to signed zero and flush results with final exponent <= 0 to signed zero with underflow=1.
REQ-022 SHALL return signed infinity with overflow=1 when final exponent >= 255.
REQ-023 SHALL return 0x7FC00000 with invalid=1 for any NaN input, 0/0, and inf/inf.
REQ-024 SHALL return signed infinity with div_by_zero=1 for nonzero finite/0; inf/finite SHALL give signed inf, finite/inf SHALL give signed zero, no flags.

Reset
REQ-025 SHALL on rst force state IDLE, o_ready=1, o_valid=0, fp_div_o=0, o_flags=0, regardless of state; an operation in progress SHALL be discarded.
REQ-026 SHALL accept new operands on the first cycle after rst deasserts.

Structure
REQ-027 SHALL place parameters' defaults, bias 127, canonical qNaN 0x7FC00000, iteration count 26 and the FSM state encoding in a shared package fp_pkg.
REQ-028 SHALL contain one sub-module fp_classify (combinational: zero/denormal, inf, NaN per operand), reusable by fp_mul.

Verification
REQ-029 SHALL cover 0x40C00000 / 0x40400000 -> 0x40000000, flags 0, o_valid 28 cycles after acceptance.
REQ-030 SHALL cover 0x3F800000 / 0x40400000 -> 0x3EAAAAAB (round-up via sticky).
REQ-031 SHALL cover 0x00000000 / 0x00000000 -> 0x7FC00000 invalid=1; 0xBF800000 / 0x00000000 -> 0xFF800000 div_by_zero=1.
REQ-032 SHALL cover 0x7F7FFFFF / 0x3F000000 -> 0x7F800000 overflow=1; 0x00800000 / 0x40000000 -> 0x00000000 underflow=1.
REQ-033 SHALL cover i_ready low 10 cycles in DONE -> fp_div_o held, o_ready low; rst pulsed mid-DIV -> o_valid 0 next cycle, o_ready 1.
REQ-034 SHALL run 40000 vectors from fp_div_I.dat against fp_div_O.dat (readmemb, {a,b} 64-bit per line) with zero mismatches.
